// File: rtl/syndrome_decoder_seq.sv
// Stabiliser-code syndrome decoder: majority-votes ROUNDS syndrome samples per axis
// and looks the voted syndrome up in a run-time programmable per-axis correction table.
module syndrome_decoder_seq #(
  parameter int NQ     = 5,
  parameter int NS     = 4,
  parameter int ROUNDS = 3
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          in_valid_i,
  input  logic [NS-1:0] syndrome_i,
  input  logic          cfg_we_i,
  input  logic [1:0]    cfg_axis_i,
  input  logic [NS-1:0] cfg_addr_i,
  input  logic [NQ-1:0] cfg_data_i,
  output logic          out_valid_o,
  output logic [NQ-1:0] correction_o,
  output logic [1:0]    axis_o,
  output logic          unstable_o
);

  localparam int CW    = $clog2(ROUNDS + 1);
  localparam int DEPTH = 1 << NS;
  localparam logic [CW-1:0] ROUNDS_C = CW'(ROUNDS);
  localparam logic [CW-1:0] MAJORITY = CW'(ROUNDS / 2);
  localparam logic [CW-1:0] LAST_RND = CW'(ROUNDS - 1);

  typedef enum logic [1:0] {
    AXIS_X = 2'b01,
    AXIS_Y = 2'b10,
    AXIS_Z = 2'b11
  } axis_e;

  axis_e                 curAxis_q, curAxis_d;
  logic [CW-1:0]         round_q, round_d;
  logic [NS-1:0][CW-1:0] voteCnt_q, voteCnt_d, voteSum;
  logic                  groupDone;
  logic                  groupUnstable;
  logic [NS-1:0]         groupSyn;

  logic                  s1Valid_q;
  logic [NS-1:0]         s1Syn_q;
  logic [1:0]            s1Axis_q;
  logic                  s1Unstable_q;

  logic                  outValid_q;
  logic [NQ-1:0]         correction_q;
  logic [1:0]            axis_q;
  logic                  unstable_q;

  logic [NQ-1:0]         tbl_q [3][DEPTH];
  logic [1:0]            wrSel;
  logic [1:0]            rdSel;

  // Counts including the sample presented this cycle, so the final sample votes too.
  always_comb begin
    voteSum       = '0;
    groupSyn      = '0;
    groupUnstable = 1'b0;
    for (int i = 0; i < NS; i++) begin
      voteSum[i]  = voteCnt_q[i] + CW'(syndrome_i[i]);
      groupSyn[i] = (voteSum[i] > MAJORITY);
      if ((voteSum[i] != '0) && (voteSum[i] != ROUNDS_C)) begin
        groupUnstable = 1'b1;
      end
    end
  end

  always_comb begin
    curAxis_d = curAxis_q;
    round_d   = round_q;
    voteCnt_d = voteCnt_q;
    groupDone = 1'b0;
    if (in_valid_i) begin
      if (round_q == LAST_RND) begin
        groupDone = 1'b1;
        round_d   = '0;
        voteCnt_d = '0;
        case (curAxis_q)
          AXIS_X:  curAxis_d = AXIS_Y;
          AXIS_Y:  curAxis_d = AXIS_Z;
          default: curAxis_d = AXIS_X;
        endcase
      end else begin
        round_d   = round_q + CW'(1);
        voteCnt_d = voteSum;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      curAxis_q <= AXIS_X;
      round_q   <= '0;
      voteCnt_q <= '0;
    end else begin
      curAxis_q <= curAxis_d;
      round_q   <= round_d;
      voteCnt_q <= voteCnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1Valid_q    <= 1'b0;
      s1Syn_q      <= '0;
      s1Axis_q     <= 2'b00;
      s1Unstable_q <= 1'b0;
    end else begin
      s1Valid_q <= groupDone;
      if (groupDone) begin
        s1Syn_q      <= groupSyn;
        s1Axis_q     <= curAxis_q;
        s1Unstable_q <= groupUnstable;
      end
    end
  end

  assign wrSel = cfg_axis_i - 2'd1;
  assign rdSel = s1Axis_q - 2'd1;

  // Lookup reads the table registers before this edge's write lands: old data wins.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outValid_q   <= 1'b0;
      correction_q <= '0;
      axis_q       <= 2'b00;
      unstable_q   <= 1'b0;
    end else begin
      outValid_q <= s1Valid_q;
      if (s1Valid_q) begin
        correction_q <= tbl_q[rdSel][s1Syn_q];
        axis_q       <= s1Axis_q;
        unstable_q   <= s1Unstable_q;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int a = 0; a < 3; a++) begin
        for (int e = 0; e < DEPTH; e++) begin
          tbl_q[a][e] <= '0;
        end
      end
    end else if (cfg_we_i && (cfg_axis_i != 2'b00)) begin
      tbl_q[wrSel][cfg_addr_i] <= cfg_data_i;
    end
  end

  assign out_valid_o  = outValid_q;
  assign correction_o = correction_q;
  assign axis_o       = axis_q;
  assign unstable_o   = unstable_q;

endmodule

// File: tb/tb_syndrome_decoder_seq.sv
// Randomised and directed bench for syndrome_decoder_seq against a sample-queue
// reference model that votes each completed group and looks it up in a shadow table.
module tb_syndrome_decoder_seq;

  localparam int NQ     = 5;
  localparam int NS     = 4;
  localparam int ROUNDS = 3;

  logic          clk;
  logic          rst;
  logic          inValid;
  logic [NS-1:0] syndrome;
  logic          cfgWe;
  logic [1:0]    cfgAxis;
  logic [NS-1:0] cfgAddr;
  logic [NQ-1:0] cfgData;
  logic          outValid;
  logic [NQ-1:0] correction;
  logic [1:0]    axis;
  logic          unstable;

  syndrome_decoder_seq #(.NQ(NQ), .NS(NS), .ROUNDS(ROUNDS)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .in_valid_i   (inValid),
    .syndrome_i   (syndrome),
    .cfg_we_i     (cfgWe),
    .cfg_axis_i   (cfgAxis),
    .cfg_addr_i   (cfgAddr),
    .cfg_data_i   (cfgData),
    .out_valid_o  (outValid),
    .correction_o (correction),
    .axis_o       (axis),
    .unstable_o   (unstable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int assertCount = 0;
  int failCount   = 0;

  // Reference model state
  logic [NQ-1:0] refTbl [3][1 << NS];
  logic [NS-1:0] samples [$];
  int            groupCount;
  bit            pendValid;
  logic [NS-1:0] pendSyn;
  logic [1:0]    pendAxis;
  bit            pendUns;
  bit            expValid;
  logic [NQ-1:0] heldCorr;
  logic [1:0]    heldAxis;
  bit            heldUns;

  // Observed result log for the gap-invariance and pulse-count checks
  logic [7:0]    obsQ [$];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    samples.delete();
    groupCount = 0;
    pendValid  = 0;
    expValid   = 0;
    heldCorr   = '0;
    heldAxis   = 2'b00;
    heldUns    = 0;
    for (int a = 0; a < 3; a++)
      for (int e = 0; e < (1 << NS); e++)
        refTbl[a][e] = '0;
  endtask

  task automatic modelEdge(input bit r, input bit iv, input logic [NS-1:0] syn,
                           input bit we, input logic [1:0] ax, input logic [NS-1:0] addr,
                           input logic [NQ-1:0] data);
    int ones;
    logic [NS-1:0] voted;
    bit uns;
    if (r) begin
      modelReset();
      return;
    end
    expValid = 0;
    if (pendValid) begin
      expValid  = 1;
      heldCorr  = refTbl[int'(pendAxis) - 1][pendSyn];
      heldAxis  = pendAxis;
      heldUns   = pendUns;
      pendValid = 0;
    end
    if (we && ax != 2'b00) refTbl[int'(ax) - 1][addr] = data;
    if (iv) begin
      samples.push_back(syn);
      if (samples.size() == ROUNDS) begin
        voted = '0;
        uns   = 0;
        for (int b = 0; b < NS; b++) begin
          ones = 0;
          foreach (samples[k]) ones += int'(samples[k][b]);
          voted[b] = (2 * ones > ROUNDS);
          if (ones != 0 && ones != ROUNDS) uns = 1;
        end
        pendValid  = 1;
        pendSyn    = voted;
        pendUns    = uns;
        pendAxis   = 2'(groupCount % 3 + 1);
        groupCount++;
        samples.delete();
      end
    end
  endtask

  task automatic applyStimulus(input bit r, input bit iv, input logic [NS-1:0] syn,
                               input bit we, input logic [1:0] ax, input logic [NS-1:0] addr,
                               input logic [NQ-1:0] data);
    @(negedge clk);
    rst = r; inValid = iv; syndrome = syn;
    cfgWe = we; cfgAxis = ax; cfgAddr = addr; cfgData = data;
    @(posedge clk);
    modelEdge(r, iv, syn, we, ax, addr, data);
    #1;
    checkOutput("outValid", 32'(outValid), 32'(expValid));
    checkOutput("correction", 32'(correction), 32'(heldCorr));
    checkOutput("axis", 32'(axis), 32'(heldAxis));
    checkOutput("unstable", 32'(unstable), 32'(heldUns));
    if (outValid) obsQ.push_back({axis, unstable, correction});
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(0, 0, '0, 0, 2'b00, '0, '0);
  endtask

  task automatic sample(input logic [NS-1:0] syn);
    applyStimulus(0, 1, syn, 0, 2'b00, '0, '0);
  endtask

  task automatic cfgWrite(input logic [1:0] ax, input logic [NS-1:0] addr, input logic [NQ-1:0] data);
    applyStimulus(0, 0, '0, 1, ax, addr, data);
  endtask

  task automatic applyReset();
    applyStimulus(1, 0, '0, 0, 2'b00, '0, '0);
    applyStimulus(1, 0, '0, 0, 2'b00, '0, '0);
  endtask

  logic [NS-1:0] seqSyn [12];
  logic [1:0]    wrAx   [6];
  logic [NS-1:0] wrAddr [6];
  logic [NQ-1:0] wrData [6];
  logic [7:0]    gaplessQ [$];
  logic [7:0]    tmpWord;

  initial begin
    rst = 1'b1; inValid = 1'b0; syndrome = '0;
    cfgWe = 1'b0; cfgAxis = 2'b00; cfgAddr = '0; cfgData = '0;
    modelReset();

    $display("[TB] reset state");
    applyReset();
    checkOutput("rstValid", 32'(outValid), 32'd0);
    checkOutput("rstCorr", 32'(correction), 32'd0);
    checkOutput("rstAxis", 32'(axis), 32'd0);

    $display("[TB] basic X lookup");
    cfgWrite(2'b01, 4'b0001, 5'b10000);
    sample(4'b0001); sample(4'b0001); sample(4'b0001);
    checkOutput("t1EarlyValid", 32'(outValid), 32'd0);
    idle(1);
    checkOutput("t1Valid", 32'(outValid), 32'd1);
    checkOutput("t1Corr", 32'(correction), 32'b10000);
    checkOutput("t1Axis", 32'(axis), 32'b01);
    checkOutput("t1Uns", 32'(unstable), 32'd0);
    idle(2);
    checkOutput("t1Hold", 32'(correction), 32'b10000);

    $display("[TB] unstable Y group");
    applyReset();
    cfgWrite(2'b10, 4'b1011, 5'b01000);
    sample(4'b0000); sample(4'b0000); sample(4'b0000);
    sample(4'b1011); sample(4'b1011); sample(4'b0011);
    idle(1);
    checkOutput("t2Valid", 32'(outValid), 32'd1);
    checkOutput("t2Corr", 32'(correction), 32'b01000);
    checkOutput("t2Axis", 32'(axis), 32'b10);
    checkOutput("t2Uns", 32'(unstable), 32'd1);
    idle(2);

    $display("[TB] back-to-back groups");
    applyReset();
    for (int k = 0; k < 16; k++) cfgWrite(2'($urandom_range(1, 3)), 4'($urandom), 5'($urandom));
    obsQ.delete();
    for (int k = 0; k < 30; k++) sample(4'($urandom));
    idle(3);
    checkOutput("t3Pulses", 32'(obsQ.size()), 32'd10);
    if (obsQ.size() == 10) begin
      tmpWord = obsQ[0]; checkOutput("t3Axis0", 32'(tmpWord[7:6]), 32'b01);
      tmpWord = obsQ[1]; checkOutput("t3Axis1", 32'(tmpWord[7:6]), 32'b10);
      tmpWord = obsQ[2]; checkOutput("t3Axis2", 32'(tmpWord[7:6]), 32'b11);
      tmpWord = obsQ[9]; checkOutput("t3Axis9", 32'(tmpWord[7:6]), 32'b01);
    end

    $display("[TB] gaps versus gapless");
    foreach (seqSyn[k]) seqSyn[k] = 4'($urandom);
    foreach (wrAx[k]) begin
      wrAx[k] = 2'($urandom_range(1, 3)); wrAddr[k] = 4'($urandom); wrData[k] = 5'($urandom);
    end
    wrAddr[0] = seqSyn[0];
    applyReset();
    foreach (wrAx[k]) cfgWrite(wrAx[k], wrAddr[k], wrData[k]);
    obsQ.delete();
    foreach (seqSyn[k]) sample(seqSyn[k]);
    idle(3);
    gaplessQ = obsQ;
    applyReset();
    foreach (wrAx[k]) cfgWrite(wrAx[k], wrAddr[k], wrData[k]);
    obsQ.delete();
    foreach (seqSyn[k]) begin
      idle($urandom_range(0, 4));
      sample(seqSyn[k]);
    end
    idle(3);
    checkOutput("t4Count", 32'(obsQ.size()), 32'(gaplessQ.size()));
    checkOutput("t4CountAbs", 32'(obsQ.size()), 32'd4);
    if (obsQ.size() == gaplessQ.size())
      foreach (obsQ[k]) checkOutput("t4Result", 32'(obsQ[k]), 32'(gaplessQ[k]));

    $display("[TB] random traffic with config writes");
    for (int k = 0; k < 150; k++)
      applyStimulus(0, ($urandom_range(0, 2) != 0), 4'($urandom), ($urandom_range(0, 3) == 0),
                    2'($urandom), 4'($urandom), 5'($urandom));
    idle(3);

    $display("[TB] write in lookup cycle");
    applyReset();
    sample(4'b0110); sample(4'b0110); sample(4'b0110);
    applyStimulus(0, 0, '0, 1, 2'b01, 4'b0110, 5'b00010);
    checkOutput("t5OldValid", 32'(outValid), 32'd1);
    checkOutput("t5OldCorr", 32'(correction), 32'b00000);
    for (int k = 0; k < 6; k++) sample(4'b0000);
    sample(4'b0110); sample(4'b0110); sample(4'b0110);
    idle(1);
    checkOutput("t5NewCorr", 32'(correction), 32'b00010);
    checkOutput("t5NewAxis", 32'(axis), 32'b01);

    $display("[TB] reset mid-group");
    cfgWrite(2'b01, 4'b0001, 5'b10000);
    sample(4'b0011); sample(4'b0011);
    applyStimulus(1, 0, '0, 1, 2'b01, 4'b0010, 5'b11111);
    applyStimulus(1, 0, '0, 0, 2'b00, '0, '0);
    checkOutput("t6RstValid", 32'(outValid), 32'd0);
    checkOutput("t6RstCorr", 32'(correction), 32'd0);
    checkOutput("t6RstAxis", 32'(axis), 32'd0);
    checkOutput("t6RstUns", 32'(unstable), 32'd0);
    idle(2);
    sample(4'b0001); sample(4'b0001); sample(4'b0001);
    idle(1);
    checkOutput("t6Valid", 32'(outValid), 32'd1);
    checkOutput("t6Corr", 32'(correction), 32'd0);
    checkOutput("t6Axis", 32'(axis), 32'b01);
    for (int k = 0; k < 6; k++) sample(4'b0000);
    sample(4'b0010); sample(4'b0010); sample(4'b0010);
    idle(1);
    checkOutput("t6RstWrite", 32'(correction), 32'd0);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
